// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and width helpers for the N-master bus arbiter
//
// Purpose: FSM state encoding and width functions used by bus_arbiter_rr and
//          rr_priority_picker.
// Ports:   none (package).

package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ADDR_WAIT  = 2'd1,
        ST_ADDR_SHIFT = 2'd2,
        ST_DATA       = 2'd3
    } state_t;

    // bus_grant carries index+1 with 0 meaning "no owner", so it needs one extra code.
    function automatic int bg_width(input int num_masters);
        return $clog2(num_masters + 1);
    endfunction

    // Width needed to hold an index 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational fixed-priority / round-robin winner picker
//
// Purpose: picks one requester from req.
//          rr_mode = 0: lowest set index wins.
//          rr_mode = 1: first set index searching upward from ptr+1, wrapping.
// Ports:
//   req     in   NUM_MASTERS  request vector
//   ptr     in   idx width    index of the previous round-robin winner
//   rr_mode in   1            selects round-robin search
//   winner  out  idx width    selected index (0 when valid is low)
//   valid   out  1            at least one request is set

module rr_priority_picker
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]               req,
    input  logic [idx_width(NUM_MASTERS)-1:0]    ptr,
    input  logic                                 rr_mode,
    output logic [idx_width(NUM_MASTERS)-1:0]    winner,
    output logic                                 valid
);

    localparam int IW = idx_width(NUM_MASTERS);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = rr_mode ? ((int'(ptr) + 1 + k) % NUM_MASTERS) : k;
            if (!valid && req[idx[IW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - N-master bus arbiter with serial slave-address capture
//
// Purpose: grants one master at a time (fixed priority or round-robin), with
//          optional preemption in fixed mode, then captures a serial slave
//          address from the owner and drives the master/slave mux selects.
// Ports:
//   clk           in   1               rising-edge clock
//   reset         in   1               asynchronous active-low reset
//   m_request     in   NUM_MASTERS     per-master request, held for the transaction
//   slave_select  in   1               serial slave address (start bit, then MSB first)
//   m_grant       out  NUM_MASTERS     one-hot grant
//   bus_grant     out  clog2(N+1)      owner index+1, 0 = no owner
//   slave_grant   out  SLAVE_ADDR_BITS captured slave address
//   busy          out  1               address phase in progress
//   addr_done     out  1               one-cycle pulse when slave_grant loads

module bus_arbiter_rr
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int SLAVE_ADDR_BITS = 2,
    parameter int RR_MODE         = 0,
    parameter int PREEMPT         = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_MASTERS-1:0]              m_request,
    input  logic                                slave_select,
    output logic [NUM_MASTERS-1:0]              m_grant,
    output logic [bg_width(NUM_MASTERS)-1:0]    bus_grant,
    output logic [SLAVE_ADDR_BITS-1:0]          slave_grant,
    output logic                                busy,
    output logic                                addr_done
);

    localparam int IW = idx_width(NUM_MASTERS);
    localparam int BW = bg_width(NUM_MASTERS);
    localparam int CW = idx_width(SLAVE_ADDR_BITS);

    state_t                     state;
    logic [IW-1:0]              owner;
    logic [IW-1:0]              rr_ptr;
    logic [CW-1:0]              bit_cnt;
    logic [SLAVE_ADDR_BITS-1:0] shift_q;
    logic [SLAVE_ADDR_BITS-1:0] assembled;
    logic [IW-1:0]              pick_idx;
    logic                       pick_valid;
    logic                       preempt;
    logic                       owner_req;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req     (m_request),
        .ptr     (rr_ptr),
        .rr_mode (RR_MODE != 0),
        .winner  (pick_idx),
        .valid   (pick_valid)
    );

    // Bits already shifted in plus the bit on the wire this cycle.
    assign assembled = SLAVE_ADDR_BITS'({shift_q, slave_select});

    assign owner_req = m_request[owner];

    // In fixed mode the picker returns the lowest set index, so a winner below
    // the owner is exactly the highest-priority preempting master.
    assign preempt = (RR_MODE == 0) && (PREEMPT != 0) && (state != ST_IDLE)
                     && pick_valid && (pick_idx < owner);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            owner       <= '0;
            rr_ptr      <= IW'(NUM_MASTERS - 1);
            bit_cnt     <= '0;
            shift_q     <= '0;
            m_grant     <= '0;
            bus_grant   <= '0;
            slave_grant <= '0;
            busy        <= 1'b0;
            addr_done   <= 1'b0;
        end else begin
            addr_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (pick_valid) begin
                    owner     <= pick_idx;
                    m_grant   <= NUM_MASTERS'(1) << pick_idx;
                    bus_grant <= BW'(pick_idx) + BW'(1);
                    busy      <= 1'b1;
                    bit_cnt   <= '0;
                    state     <= ST_ADDR_WAIT;
                    if (RR_MODE != 0) begin
                        rr_ptr <= pick_idx;
                    end
                end
            end else if (preempt) begin
                // Checked before release: the owner dropping on this edge does not matter.
                owner       <= pick_idx;
                m_grant     <= NUM_MASTERS'(1) << pick_idx;
                bus_grant   <= BW'(pick_idx) + BW'(1);
                slave_grant <= '0;
                busy        <= 1'b1;
                bit_cnt     <= '0;
                state       <= ST_ADDR_WAIT;
            end else if (!owner_req) begin
                // Release always passes through IDLE, giving a turnaround cycle.
                m_grant     <= '0;
                bus_grant   <= '0;
                slave_grant <= '0;
                busy        <= 1'b0;
                bit_cnt     <= '0;
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_ADDR_WAIT: begin
                        if (slave_select) begin
                            bit_cnt <= '0;
                            shift_q <= '0;
                            state   <= ST_ADDR_SHIFT;
                        end
                    end
                    ST_ADDR_SHIFT: begin
                        shift_q <= assembled;
                        if (bit_cnt == CW'(SLAVE_ADDR_BITS - 1)) begin
                            slave_grant <= assembled;
                            busy        <= 1'b0;
                            addr_done   <= 1'b1;
                            state       <= ST_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - testbench for bus_arbiter_rr (fixed/preempt and round-robin instances)

module tb_bus_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] req_f, req_r;
    logic       ss_f, ss_r;
    logic [3:0] grant_f, grant_r;
    logic [2:0] bg_f, bg_r;
    logic [1:0] sg_f, sg_r;
    logic       busy_f, busy_r, done_f, done_r;

    bus_arbiter_rr #(.NUM_MASTERS(4), .SLAVE_ADDR_BITS(2), .RR_MODE(0), .PREEMPT(1)) u_fixed (
        .clk(clk), .reset(reset), .m_request(req_f), .slave_select(ss_f),
        .m_grant(grant_f), .bus_grant(bg_f), .slave_grant(sg_f), .busy(busy_f), .addr_done(done_f)
    );

    bus_arbiter_rr #(.NUM_MASTERS(4), .SLAVE_ADDR_BITS(2), .RR_MODE(1), .PREEMPT(0)) u_rr (
        .clk(clk), .reset(reset), .m_request(req_r), .slave_select(ss_r),
        .m_grant(grant_r), .bus_grant(bg_r), .slave_grant(sg_r), .busy(busy_r), .addr_done(done_r)
    );

    typedef struct {
        logic [3:0]  req;
        logic        ss;
        logic [10:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [10:0] exp;
        string       name;
        bit          rr;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic logic [10:0] pk(input logic [3:0] g, input logic [2:0] bg,
                                       input logic [1:0] sg, input logic b, input logic d);
        return {g, bg, sg, b, d};
    endfunction

    function automatic logic [10:0] act(input bit rr);
        return rr ? {grant_r, bg_r, sg_r, busy_r, done_r} : {grant_f, bg_f, sg_f, busy_f, done_f};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("FAIL %s: got grant=%b bus_grant=%0d slave_grant=%b busy=%b addr_done=%b, want grant=%b bus_grant=%0d slave_grant=%b busy=%b addr_done=%b",
                     name, got[10:7], got[6:4], got[3:2], got[1], got[0],
                     want[10:7], want[6:4], want[3:2], want[1], want[0]);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic s, input logic [10:0] e, input string n);
        vecs.push_back('{req: r, ss: s, exp: e, name: n});
    endtask

    task automatic run_vecs(input bit rr);
        sb_t s;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (rr) begin
                req_r = vecs[i].req;
                ss_r  = vecs[i].ss;
            end else begin
                req_f = vecs[i].req;
                ss_f  = vecs[i].ss;
            end
            sb.push_back('{exp: vecs[i].exp, name: vecs[i].name, rr: rr});
            @(posedge clk);
            #1;
            s = sb.pop_front();
            check(s.name, act(s.rr), s.exp);
        end
        vecs.delete();
    endtask

    initial begin
        logic [3:0] g;
        logic [2:0] b;
        logic [1:0] a;
        int         o;

        reset = 1'b0;
        req_f = '0;
        req_r = '0;
        ss_f  = 1'b0;
        ss_r  = 1'b0;

        // Reset held with random requests: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_f = 4'($urandom);
            req_r = 4'($urandom);
            ss_f  = 1'($urandom);
            ss_r  = 1'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("reset_hold_fixed_%0d", i), act(1'b0), '0);
            check($sformatf("reset_hold_rr_%0d", i), act(1'b1), '0);
        end
        @(negedge clk);
        req_f = '0;
        req_r = '0;
        ss_f  = 1'b0;
        ss_r  = 1'b0;
        reset = 1'b1;

        // Fixed priority with preemption.
        add(4'b0000, 1'b0, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0), "post_reset_idle");
        add(4'b0010, 1'b0, pk(4'b0010, 3'd2, 2'b00, 1'b1, 1'b0), "grant_m1");
        add(4'b0010, 1'b0, pk(4'b0010, 3'd2, 2'b00, 1'b1, 1'b0), "m1_wait_0");
        add(4'b0010, 1'b0, pk(4'b0010, 3'd2, 2'b00, 1'b1, 1'b0), "m1_wait_1");
        add(4'b0010, 1'b1, pk(4'b0010, 3'd2, 2'b00, 1'b1, 1'b0), "m1_start");
        add(4'b0010, 1'b1, pk(4'b0010, 3'd2, 2'b00, 1'b1, 1'b0), "m1_addr_msb");
        add(4'b0010, 1'b0, pk(4'b0010, 3'd2, 2'b10, 1'b0, 1'b1), "m1_addr_done");
        add(4'b0010, 1'b0, pk(4'b0010, 3'd2, 2'b10, 1'b0, 1'b0), "m1_data_pulse_once");
        add(4'b0000, 1'b0, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0), "m1_release");
        add(4'b0000, 1'b0, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0), "idle_hold");
        add(4'b1000, 1'b0, pk(4'b1000, 3'd4, 2'b00, 1'b1, 1'b0), "grant_m3");
        add(4'b1000, 1'b1, pk(4'b1000, 3'd4, 2'b00, 1'b1, 1'b0), "m3_start");
        add(4'b0000, 1'b1, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0), "m3_drop_in_shift");
        add(4'b0000, 1'b0, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0), "idle_after_drop");
        add(4'b0100, 1'b0, pk(4'b0100, 3'd3, 2'b00, 1'b1, 1'b0), "grant_m2");
        add(4'b0100, 1'b1, pk(4'b0100, 3'd3, 2'b00, 1'b1, 1'b0), "m2_start");
        add(4'b0100, 1'b0, pk(4'b0100, 3'd3, 2'b00, 1'b1, 1'b0), "m2_addr_msb");
        add(4'b0100, 1'b1, pk(4'b0100, 3'd3, 2'b01, 1'b0, 1'b1), "m2_addr_done");
        add(4'b0100, 1'b0, pk(4'b0100, 3'd3, 2'b01, 1'b0, 1'b0), "m2_data");
        add(4'b0101, 1'b0, pk(4'b0001, 3'd1, 2'b00, 1'b1, 1'b0), "preempt_by_m0");
        add(4'b0101, 1'b0, pk(4'b0001, 3'd1, 2'b00, 1'b1, 1'b0), "m0_wait");
        add(4'b0100, 1'b0, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0), "m0_release_no_rearb");
        add(4'b0100, 1'b0, pk(4'b0100, 3'd3, 2'b00, 1'b1, 1'b0), "regrant_m2");
        add(4'b0010, 1'b0, pk(4'b0010, 3'd2, 2'b00, 1'b1, 1'b0), "preempt_beats_release");
        add(4'b0000, 1'b0, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0), "m1_release_2");
        add(4'b1110, 1'b0, pk(4'b0010, 3'd2, 2'b00, 1'b1, 1'b0), "simultaneous_lowest_wins");
        add(4'b0000, 1'b0, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0), "final_release");
        run_vecs(1'b0);

        // Round-robin, all four requesting: owners 0,1,2,3,0.
        for (int m = 0; m < 5; m++) begin
            o = m % 4;
            g = 4'(1 << o);
            b = 3'(o + 1);
            a = 2'(m);
            add(4'b1111, 1'b0, pk(g, b, 2'b00, 1'b1, 1'b0), $sformatf("rr_grant_%0d", m));
            add(4'b1111, 1'b1, pk(g, b, 2'b00, 1'b1, 1'b0), $sformatf("rr_start_%0d", m));
            add(4'b1111, a[1], pk(g, b, 2'b00, 1'b1, 1'b0), $sformatf("rr_msb_%0d", m));
            add(4'b1111, a[0], pk(g, b, a, 1'b0, 1'b1), $sformatf("rr_addr_done_%0d", m));
            if (m < 4) begin
                add(4'b1111 & ~g, 1'b0, pk(4'b0000, 3'd0, 2'b00, 1'b0, 1'b0),
                    $sformatf("rr_release_%0d", m));
            end else begin
                add(4'b1111, 1'b0, pk(g, b, a, 1'b0, 1'b0), "rr_data_hold");
            end
        end
        run_vecs(1'b1);

        // Asynchronous reset between edges while master 0 is in DATA.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_rr_immediate", act(1'b1), '0);
        check("async_reset_fixed_immediate", act(1'b0), '0);
        @(negedge clk);
        reset = 1'b1;
        add(4'b1111, 1'b0, pk(4'b0001, 3'd1, 2'b00, 1'b1, 1'b0), "rr_ptr_restart_m0");
        run_vecs(1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
